vin_patgen: RTL and testbench

- Video source that drives the video-input mixer interface: the same sync, valid and two-pixels-per-clock 48-bit RGB stream the color mixer consumes.
- Generates programmable raster timing plus one of four test patterns: solid, gray ramp, 8 color bars, checkerboard.
- Sits in place of, or muxed with, the external video receiver, ahead of the color mixer.
- Used for bring-up and panel characterisation without a host video source.

---
 rtl/vin_pkg.sv | 32 +++
 rtl/vin_patgen_if.sv | 22 ++
 rtl/vin_timing.sv | 79 +++++++
 rtl/vin_patgen.sv | 155 +++++++++++++++
 tb/tb_vin_patgen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vin_pkg.sv
// Shared definitions for the video-input pattern source and the color mixer:
// pattern codes, the color-bar table and the RGB888 pixel-pair layout.
package vin_pkg;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Pixel-pair word: even pixel in the upper half, odd pixel in the lower half.
    localparam int PIX_W    = 24;
    localparam int PAIR_W   = 48;
    localparam int EVEN_LSB = 24;
    localparam int ODD_LSB  = 0;

    typedef logic [PIX_W-1:0] rgb_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vin_state_t;

    localparam rgb_t BAR_COLOR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic rgb_t bar_color(input logic [2:0] idx);
        return BAR_COLOR[idx];
    endfunction

endpackage

// File: rtl/vin_patgen_if.sv
// Video stream toward the color mixer: syncs, pixel-pair data and frame marker.
interface vin_patgen_if;
    import vin_pkg::*;

    // out_valid marks an active pixel pair; there is no backpressure, so the
    // sink must consume every cycle in which out_valid is high.
    logic              out_vsync;
    logic              out_hsync;
    logic              out_valid;
    logic              frame_start;
    logic [PAIR_W-1:0] out_color;
    vin_state_t        dbg_state;

    modport master (
        output out_vsync, out_hsync, out_valid, frame_start, out_color, dbg_state
    );

    modport slave (
        input out_vsync, out_hsync, out_valid, frame_start, out_color, dbg_state
    );

endinterface

// File: rtl/vin_timing.sv
// Raster timing: horizontal/vertical counters, IDLE/RUN control and the
// sync/active/frame flags decoded from the current counter state.
module vin_timing
    import vin_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 1200,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4,
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output vin_state_t    state,
    output logic          running,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          frame_start,
    output logic          bar_clr
);

    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_SYNC + H_BP + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_SYNC + V_BP + V_ACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (hcnt == HW'(H_TOTAL - 1)) begin
                        hcnt <= '0;
                        if (vcnt == VW'(V_TOTAL - 1)) begin
                            // Only the last clock of a frame may stop the raster.
                            vcnt <= '0;
                            if (!en) state <= ST_IDLE;
                        end else begin
                            vcnt <= vcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign running     = (state == ST_RUN);
    assign hsync       = running && (int'(hcnt) < H_SYNC);
    assign vsync       = running && (int'(vcnt) < V_SYNC);
    assign active      = running
                         && (int'(hcnt) >= H_ACT_START) && (int'(hcnt) < H_ACT_END)
                         && (int'(vcnt) >= V_ACT_START) && (int'(vcnt) < V_ACT_END);
    assign frame_start = running && (hcnt == '0) && (vcnt == '0);
    // Bar counter is cleared on the clock just before each active span.
    assign bar_clr     = (int'(hcnt) == H_ACT_START - 1);

endmodule

// File: rtl/vin_patgen.sv
// Test-pattern video source: raster timing plus solid, ramp, bars or checker
// content, delivered as registered two-pixels-per-clock RGB888.
module vin_patgen
    import vin_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 1200,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4,
    parameter int BAR_W    = H_ACTIVE / 8,
    parameter int CHK_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] fg_color,
    vin_patgen_if.master vid
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = $clog2(BAR_W) + 1;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    vin_state_t    state;
    logic          running;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          frame_start;
    logic          bar_clr;

    vin_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .state       (state),
        .running     (running),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start),
        .bar_clr     (bar_clr)
    );

    assign vid.dbg_state = state;

    logic [1:0]    pat_q;
    rgb_t          fg_q;
    logic [2:0]    bar_idx;
    logic [BW-1:0] bar_sub;

    // Pattern and color are sampled once per frame so content never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_SOLID;
            fg_q  <= '0;
        end else if (frame_start) begin
            pat_q <= pat_sel;
            fg_q  <= fg_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx <= '0;
            bar_sub <= '0;
        end else if (bar_clr) begin
            bar_idx <= '0;
            bar_sub <= '0;
        end else if (active) begin
            if (bar_sub == BW'(BAR_W - 1)) begin
                bar_sub <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_sub <= bar_sub + 1'b1;
            end
        end
    end

    logic [HW-1:0] ax;
    logic [VW-1:0] ay;
    logic [HW-1:0] px;
    logic [7:0]    gray_even;
    logic [7:0]    gray_odd;
    logic          chk_white;

    assign ax        = hcnt - HW'(H_SYNC + H_BP);
    assign ay        = vcnt - VW'(V_SYNC + V_BP);
    assign px        = ax << 1;
    assign gray_even = 8'(px);
    // Even pixel x has bit 0 clear, so x+1 only sets bit 0.
    assign gray_odd  = gray_even | 8'd1;
    assign chk_white = 1'(px >> CHK_LOG2) ^ 1'(ay >> CHK_LOG2);

    logic [PAIR_W-1:0] pair;

    always_comb begin
        pair = '0;
        case (pat_q)
            PAT_SOLID: begin
                pair[EVEN_LSB +: PIX_W] = fg_q;
                pair[ODD_LSB  +: PIX_W] = fg_q;
            end
            PAT_RAMP: begin
                pair[EVEN_LSB +: PIX_W] = {gray_even, gray_even, gray_even};
                pair[ODD_LSB  +: PIX_W] = {gray_odd, gray_odd, gray_odd};
            end
            PAT_BARS: begin
                pair[EVEN_LSB +: PIX_W] = bar_color(bar_idx);
                pair[ODD_LSB  +: PIX_W] = bar_color(bar_idx);
            end
            default: begin
                pair[EVEN_LSB +: PIX_W] = chk_white ? 24'hFFFFFF : 24'h000000;
                pair[ODD_LSB  +: PIX_W] = chk_white ? 24'hFFFFFF : 24'h000000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.out_hsync   <= 1'b0;
            vid.out_vsync   <= 1'b0;
            vid.out_valid   <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.out_color   <= '0;
        end else begin
            vid.out_hsync   <= hsync;
            vid.out_vsync   <= vsync;
            vid.out_valid   <= active;
            vid.frame_start <= frame_start;
            vid.out_color   <= (active && running) ? pair : '0;
        end
    end

endmodule

// File: tb/tb_vin_patgen.sv
// Directed bench for vin_patgen on a tiny 14x7 raster: timing, pattern content,
// frame-boundary latching, stop at end of frame and asynchronous reset.
module tb_vin_patgen;
    import vin_pkg::*;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] fg_color = 24'h0;

    vin_patgen_if vid ();

    vin_patgen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .BAR_W    (1), .CHK_LOG2 (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pat_sel  (pat_sel),
        .fg_color (fg_color),
        .vid      (vid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] ramp_tab [8] = '{
        48'h000000010101, 48'h020202030303, 48'h040404050505, 48'h060606070707,
        48'h080808090909, 48'h0A0A0A0B0B0B, 48'h0C0C0C0D0D0D, 48'h0E0E0E0F0F0F
    };
    logic [47:0] bars_tab [8] = '{
        48'hFFFFFFFFFFFF, 48'hFFFF00FFFF00, 48'h00FFFF00FFFF, 48'h00FF0000FF00,
        48'hFF00FFFF00FF, 48'hFF0000FF0000, 48'h0000FF0000FF, 48'h000000000000
    };
    // Bit ax set = white word on that active line.
    logic [7:0] chk_rows [4] = '{8'hAA, 8'hAA, 8'h55, 8'h55};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] bundle();
        return {vid.out_vsync, vid.out_hsync, vid.out_valid, vid.frame_start, vid.out_color};
    endfunction

    // Expected outputs for frame clock t (counter state hcnt=t%14, vcnt=t/14).
    function automatic logic [51:0] exp_bundle(input int kind, input logic [23:0] fg, input int t);
        int h;
        int v;
        int ax;
        int ay;
        logic vs;
        logic hs;
        logic val;
        logic fs;
        logic [47:0] c;
        logic [7:0] row;
        h   = t % HT;
        v   = t / HT;
        hs  = (h < 2);
        vs  = (v < 1);
        val = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
        fs  = (t == 0);
        c   = 48'h0;
        if (val) begin
            ax = h - 4;
            ay = v - 2;
            case (kind)
                0: c = {fg, fg};
                1: c = ramp_tab[ax];
                2: c = bars_tab[ax];
                default: begin
                    row = chk_rows[ay];
                    c = row[ax] ? 48'hFFFFFFFFFFFF : 48'h000000000000;
                end
            endcase
        end
        return {vs, hs, val, fs, c};
    endfunction

    // Checks one full frame starting at the frame_start sample; applies new
    // inputs mid-frame so latching can be observed on the following frame.
    task automatic run_frame(input string tag, input int kind, input logic [23:0] fg_exp,
                             input logic nx_en, input logic [1:0] nx_pat, input logic [23:0] nx_fg);
        for (int t = 0; t < FT; t++) begin
            chk($sformatf("%s_t%0d", tag, t), 64'(bundle()), 64'(exp_bundle(kind, fg_exp, t)));
            if (t == 50) begin
                en       = nx_en;
                pat_sel  = nx_pat;
                fg_color = nx_fg;
            end
            if (t < FT - 1) step();
        end
    endtask

    task automatic wait_fs(input string tag, output int cycles);
        cycles = 0;
        while (cycles < 12 && vid.frame_start !== 1'b1) begin
            step();
            cycles++;
        end
        chk({tag, "_fs_seen"}, 64'(vid.frame_start), 64'd1);
    endtask

    int lat;

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 64'(bundle()), 64'd0);
        chk("reset_state", 64'(vid.dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_outputs", 64'(bundle()), 64'd0);
        chk("idle_state", 64'(vid.dbg_state), 64'(ST_IDLE));

        // Start: IDLE->RUN on the first edge, first frame output on the second
        fg_color = 24'h123456;
        pat_sel  = PAT_SOLID;
        en       = 1'b1;
        wait_fs("start", lat);
        chk("start_latency", 64'(lat), 64'd2);
        chk("run_state", 64'(vid.dbg_state), 64'(ST_RUN));

        run_frame("solid1", 0, 24'h123456, 1'b1, PAT_SOLID, 24'hABCDEF);
        step();
        run_frame("solid2", 0, 24'hABCDEF, 1'b1, PAT_RAMP, 24'hABCDEF);
        step();
        run_frame("ramp", 1, 24'hABCDEF, 1'b1, PAT_BARS, 24'hABCDEF);
        step();
        run_frame("bars", 2, 24'hABCDEF, 1'b1, PAT_CHECK, 24'hABCDEF);
        step();
        run_frame("checker", 3, 24'hABCDEF, 1'b0, PAT_SOLID, 24'hABCDEF);

        // en dropped mid-frame: the frame completed, now everything stays low
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("stopped_c%0d", k), 64'(bundle()), 64'd0);
        end
        chk("stopped_state", 64'(vid.dbg_state), 64'(ST_IDLE));

        // Restart, then assert reset in the middle of an active line
        en = 1'b1;
        wait_fs("restart", lat);
        chk("restart_latency", 64'(lat), 64'd2);
        repeat (33) step();
        chk("pre_rst_word", 64'(bundle()), 64'(exp_bundle(0, 24'hABCDEF, 33)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'(bundle()), 64'd0);
        chk("async_rst_state", 64'(vid.dbg_state), 64'(ST_IDLE));
        repeat (2) step();
        chk("held_rst_outputs", 64'(bundle()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs("post_rst", lat);
        chk("post_rst_latency", 64'(lat), 64'd2);
        chk("post_rst_syncs", 64'({vid.out_vsync, vid.out_hsync}), 64'd3);
        run_frame("post_rst", 0, 24'hABCDEF, 1'b1, PAT_SOLID, 24'hABCDEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
